// File: rtl/receiver_if.sv
// rtl/receiver_if.sv - received-word output bundle of the UART receiver
interface receiver_if #(
    parameter int DATA_LENGTH = 8
);
    logic [DATA_LENGTH-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_frame_error;
    logic                   rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_error,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_frame_error,
        input rx_busy
    );
endinterface

// File: rtl/receiver.sv
// rtl/receiver.sv - 16x-oversampled UART receiver, 1 start / DATA_LENGTH data / 1 stop, no parity
module receiver #(
    parameter int DATA_LENGTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx,
    input  logic          baud_timer,
    receiver_if.master    rx_out
);
    localparam int IDX_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RECEIVE = 2'd2,
        S_STOP    = 2'd3
    } state_t;

    state_t                 state;
    logic [3:0]             baud_count;
    logic [IDX_W-1:0]       bit_index;
    logic [DATA_LENGTH-1:0] shift;
    logic                   rx_s1;
    logic                   rx_s2;
    logic                   rx_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            baud_count            <= 4'd0;
            bit_index             <= '0;
            shift                 <= '0;
            rx_s1                 <= 1'b1;
            rx_s2                 <= 1'b1;
            rx_prev               <= 1'b1;
            rx_out.rx_data        <= '0;
            rx_out.rx_valid       <= 1'b0;
            rx_out.rx_frame_error <= 1'b0;
            rx_out.rx_busy        <= 1'b0;
        end else begin
            rx_s1                 <= rx;
            rx_s2                 <= rx_s1;
            rx_prev               <= rx_s2;
            rx_out.rx_valid       <= 1'b0;
            rx_out.rx_frame_error <= 1'b0;
            rx_out.rx_busy        <= (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    baud_count <= 4'd0;
                    // Edge-triggered so a held-low break line never restarts reception
                    if (rx_prev && !rx_s2) begin
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (baud_timer) begin
                        if (baud_count == 4'd7) begin
                            if (!rx_s2) begin
                                state      <= S_RECEIVE;
                                baud_count <= 4'd0;
                                bit_index  <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                end

                S_RECEIVE: begin
                    if (baud_timer) begin
                        if (baud_count == 4'd15) begin
                            shift      <= {rx_s2, shift[DATA_LENGTH-1:1]};
                            baud_count <= 4'd0;
                            if (bit_index == IDX_W'(DATA_LENGTH - 1)) begin
                                state <= S_STOP;
                            end else begin
                                bit_index <= bit_index + IDX_W'(1);
                            end
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                end

                S_STOP: begin
                    if (baud_timer) begin
                        if (baud_count == 4'd15) begin
                            // Leaving at mid stop bit leaves room to catch a back-to-back start edge
                            if (rx_s2) begin
                                rx_out.rx_data  <= shift;
                                rx_out.rx_valid <= 1'b1;
                            end else begin
                                rx_out.rx_frame_error <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            baud_count <= baud_count + 4'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - scoreboard bench for the UART receiver
module tb_receiver;
    localparam int BIT_CLKS = 64;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic baud_timer = 1'b0;

    receiver_if #(.DATA_LENGTH(8)) bus ();

    receiver #(.DATA_LENGTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .baud_timer (baud_timer),
        .rx_out     (bus)
    );

    exp_t       q[$];
    int         n_vec = 0;
    int         n_fail = 0;
    bit         ignore_window = 1'b0;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud_timer = (cnt == 0);
            cnt = (cnt + 1) % 4;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_data"}, 16'(bus.rx_data), 16'h0);
        chk({tag, "_rx_valid"}, 16'(bus.rx_valid), 16'h0);
        chk({tag, "_rx_frame_error"}, 16'(bus.rx_frame_error), 16'h0);
        chk({tag, "_rx_busy"}, 16'(bus.rx_busy), 16'h0);
    endtask

    // Monitor: every output event pops the oldest expectation
    always @(negedge clk) begin
        if (reset_n && (bus.rx_valid || bus.rx_frame_error)) begin
            chk("valid_err_exclusive", 16'(bus.rx_valid & bus.rx_frame_error), 16'h0);
            if (ignore_window) begin
                if (bus.rx_valid) begin
                    n_vec++;
                    if (bus.rx_data == 8'hC3) begin
                        n_fail++;
                        $display("FAIL reset_discard: got 0x%0h, expected anything but 0xc3", bus.rx_data);
                    end
                end
            end else if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: valid=%0b err=%0b data=0x%0h, expected none at %0t",
                         bus.rx_valid, bus.rx_frame_error, bus.rx_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_error_flag", 16'(bus.rx_frame_error), 16'(e.err));
                if (e.err) chk("data_held_on_error", 16'(bus.rx_data), 16'(last_good));
                else       chk("rx_data", 16'(bus.rx_data), 16'(e.data));
            end
            if (bus.rx_valid) last_good = bus.rx_data;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bclk, input int rst_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < bclk; c++) begin
                @(negedge clk);
                if (i == rst_bit && c == 4) begin
                    reset_n = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    last_good = 8'h00;
                    check_reset_outputs("midframe_reset");
                end
            end
        end
    endtask

    task automatic expect_word(input logic [7:0] d);
        exp_t e;
        e.err = 1'b0;
        e.data = d;
        q.push_back(e);
    endtask

    initial begin
        logic [7:0] loop_vals [4];
        exp_t ee;
        loop_vals = '{8'h00, 8'hFF, 8'h3C, 8'h81};

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single frame, with busy observed mid-frame and after
        expect_word(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, BIT_CLKS, -1);
            begin
                repeat (5 * BIT_CLKS) @(negedge clk);
                chk("busy_mid_frame", 16'(bus.rx_busy), 16'h1);
            end
        join
        chk("busy_after_frame", 16'(bus.rx_busy), 16'h0);
        repeat (BIT_CLKS) @(negedge clk);

        // Back-to-back frames
        foreach (loop_vals[i]) expect_word(loop_vals[i]);
        foreach (loop_vals[i]) send_frame(loop_vals[i], 1'b1, BIT_CLKS, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_during_glitch", 16'(bus.rx_busy), 16'h1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (24) @(negedge clk);
        chk("busy_after_glitch", 16'(bus.rx_busy), 16'h0);
        repeat (2 * BIT_CLKS) @(negedge clk);

        // Framing error followed by a long break
        ee.err = 1'b1;
        ee.data = 8'h5A;
        q.push_back(ee);
        send_frame(8'h5A, 1'b0, BIT_CLKS, -1);
        repeat (30 * BIT_CLKS) @(negedge clk);
        chk("busy_during_break", 16'(bus.rx_busy), 16'h0);
        chk("data_after_break", 16'(bus.rx_data), 16'h81);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);

        // Reset during data bit 4 of 0xC3
        ignore_window = 1'b1;
        send_frame(8'hC3, 1'b1, BIT_CLKS, 5);
        rx = 1'b1;
        repeat (8 * BIT_CLKS) @(negedge clk);
        ignore_window = 1'b0;
        expect_word(8'h77);
        send_frame(8'h77, 1'b1, BIT_CLKS, -1);
        repeat (BIT_CLKS) @(negedge clk);

        // Bit-rate skew, compressed then stretched
        expect_word(8'h55);
        send_frame(8'h55, 1'b1, 62, -1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        expect_word(8'h55);
        send_frame(8'h55, 1'b1, 66, -1);

        for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'h0);
        repeat (BIT_CLKS) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/receiver.md
# receiver

UART serial receiver: recovers `DATA_LENGTH`-bit words from the asynchronous `rx` line using the shared 16x-oversampling `baud_timer` tick, and presents each word with a one-cycle valid pulse. It sits directly downstream of `transmitter`, on the far end of the serial line. It uses the same frame format: 1 start bit (0), `DATA_LENGTH` data bits LSB first, 1 stop bit (1), no parity, 16 ticks per bit.

## Interface
- `DATA_LENGTH`, default 8: data bits per frame (2..16).
- `clk`  input  1  single clock; all logic on rising edge.
- `reset_n`  input  1  synchronous active-low reset.
- `rx`  input  1  asynchronous serial input; idle high.
- `baud_timer`  input  1  one-`clk` pulse at 16x the bit rate; same source as the transmitter's.
- `rx_data`  output  `DATA_LENGTH`  last correctly framed word; holds until the next good frame.
- `rx_valid`  output  1  one-cycle pulse: `rx_data` updated this cycle.
- `rx_frame_error`  output  1  one-cycle pulse: stop bit sampled low.
- `rx_busy`  output  1  high whenever state ≠ idle.

## Operation
- Input sync: `rx` passes through two flops (`rx_s1`, `rx_s2`) plus a third flop `rx_prev` for edge detection. All three reset to 1. All decisions use `rx_s2`.
- Registers:
  - state (2 bits)
  - `baud_count` (4 bits): advances only when `baud_timer` = 1
  - `bit_index` (`$clog2(DATA_LENGTH)` bits)
  - shift register (`DATA_LENGTH` bits)
- States:
  - idle:
    - `baud_count` = 0.
    - On a falling edge (`rx_prev` = 1, `rx_s2` = 0) → start.
    - A line held low (break) does not retrigger.
  - start:
    - On a tick with `baud_count` = 7 (mid start bit), check `rx_s2`.
    - `rx_s2` = 0 → receive, with `baud_count` = 0 and `bit_index` = 0.
    - `rx_s2` = 1 → idle (glitch rejected, no output).
    - On other ticks, `baud_count` increments.
  - receive:
    - On a tick with `baud_count` = 15: shift = {`rx_s2`, shift[DATA_LENGTH-1:1]}, `baud_count` = 0.
    - If `bit_index` = DATA_LENGTH-1 → stop; else `bit_index` increments.
  - stop:
    - On a tick with `baud_count` = 15, sample `rx_s2`.
    - `rx_s2` = 1: `rx_data` ← shift, `rx_valid` pulse.
    - `rx_s2` = 0: `rx_frame_error` pulse; `rx_data` unchanged.
    - Either way → idle.
  - Illegal state encoding → idle.
- Samples fall at 8+16k ticks after the detected edge, i.e. mid-bit.
- Returning to idle at mid stop bit allows a back-to-back start bit to be caught.
- `rx_valid` and `rx_frame_error` are registered, never both high, and low in every cycle except the one following the sampling tick.
- Reset mid-frame:
  - Returns to idle with all outputs at reset values and the partial word discarded.
  - A frame already in progress on the line is not recovered. The first falling edge after reset starts reception.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `rx_frame_error` = 0, `rx_busy` = 0.
  - State idle; counters 0; shift register 0.
  - `rx_s1`, `rx_s2`, `rx_prev` = 1.
- Pin-to-detect latency: 2 `clk` (synchronizer). Start is entered on the 3rd `clk` edge after `rx` falls, assuming setup is met.
- `rx_busy` rises the cycle after start is entered and falls the cycle after the return to idle.
- Frame latency: `rx_valid` is asserted 1 `clk` after the stop-bit sampling tick. That tick is tick #(8 + 16·(DATA_LENGTH+1)) after edge detect, i.e. tick 152 for DATA_LENGTH = 8.
- A `baud_timer` pulse arriving in the same cycle as the state transition is consumed by the transition. Counting in the new state begins on the next tick.
- No backpressure: a consumer must take `rx_data` on `rx_valid`. The word is held at least until the next good frame (≥ 10 bit-times).
- Tolerates ±3% bit-rate mismatch between transmitter and receiver.

## Test plan
- Clock setup for all scenarios: `baud_timer` every 4 `clk`, DATA_LENGTH = 8.
- Single frame: drive 0xA5 on `rx` → one `rx_valid` pulse with `rx_data` = 0xA5, `rx_frame_error` = 0. `rx_busy` is high throughout the frame and low one cycle after the stop sample.
- Loopback: `transmitter.tx` → `rx`; send 0x00, 0xFF, 0x3C, 0x81 back-to-back → four `rx_valid` pulses carrying the same values in order, no errors.
- Glitch: `rx` low for 5 ticks, then high → start aborts, no `rx_valid`/`rx_frame_error`, `rx_busy` returns to 0 by tick 8.
- Framing error: send 0x5A with the stop bit forced low, then the line held low (break) for 3 frame-times → exactly one `rx_frame_error` pulse, `rx_data` keeps its prior value, no further activity until `rx` goes high and falls again.
- Reset mid-frame: assert `reset_n` = 0 for 1 cycle during data bit 4 of 0xC3 → all outputs at reset values the next cycle. The remainder of that frame must not produce `rx_valid` = 1 with 0xC3. A subsequent clean frame 0x77 → `rx_data` = 0x77.
- Bit-rate skew: transmit at 16 ticks/bit ±3% (stretched/compressed bit periods) with data 0x55 → `rx_data` = 0x55, no error.
